// File: rtl/alu_issue.sv
// ID->EX issue stage: decodes a MIPS word into ALU operands and holds them in one valid/ready slot.
// Optional operand forwarding is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic             fwd_we,
  input  logic [4:0]       fwd_rd,
  input  logic [31:0]      fwd_data,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_op,
  output logic [4:0]       dst,
  output logic             wb_en,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOR  = 5'd6;
  localparam logic [4:0] OP_ADDU = 5'd7;
  localparam logic [4:0] OP_SUBU = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_SLL  = 5'd11;
  localparam logic [4:0] OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_MOV  = 5'd14;
  localparam logic [4:0] OP_LUI  = 5'd15;

  logic [5:0]  opc_s, funct_s;
  logic [4:0]  rs_f_s, rt_f_s, rd_f_s, shamt_s;
  logic [15:0] imm_s;
  logic [31:0] rs_val_s, rt_val_s;

  logic [4:0]  dec_op_s, dec_dst_s;
  logic [31:0] dec_a_s, dec_b_s;
  logic        dec_wb_s, dec_ill_s, wb_cond_s;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       alu_op_q, alu_op_d, dst_q, dst_d;
  logic             wb_en_q, wb_en_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             load_s, hs_s;

  assign opc_s   = instr[31:26];
  assign rs_f_s  = instr[25:21];
  assign rt_f_s  = instr[20:16];
  assign rd_f_s  = instr[15:11];
  assign shamt_s = instr[10:6];
  assign funct_s = instr[5:0];
  assign imm_s   = instr[15:0];

  // Operand selection (forwarded result overrides register-file data)
  always_comb begin
    rs_val_s = rs_data;
    rt_val_s = rt_data;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_we && (fwd_rd != 5'd0)) begin
      if (fwd_rd == rs_f_s) begin
        rs_val_s = fwd_data;
      end else begin
        rs_val_s = rs_data;
      end
      if (fwd_rd == rt_f_s) begin
        rt_val_s = fwd_data;
      end else begin
        rt_val_s = rt_data;
      end
    end else begin
      rs_val_s = rs_data;
      rt_val_s = rt_data;
    end
`endif
  end

  // Instruction decode into ALU triple, destination and writeback enable
  always_comb begin
    dec_op_s  = OP_NOP;
    dec_a_s   = rs_val_s;
    dec_b_s   = rt_val_s;
    dec_dst_s = rd_f_s;
    wb_cond_s = 1'b1;
    dec_ill_s = 1'b0;
    case (opc_s)
      6'h00: begin
        case (funct_s)
          6'h20: dec_op_s = OP_ADD;
          6'h21: dec_op_s = OP_ADDU;
          6'h22: dec_op_s = OP_SUB;
          6'h23: dec_op_s = OP_SUBU;
          6'h24: dec_op_s = OP_AND;
          6'h25: dec_op_s = OP_OR;
          6'h26: dec_op_s = OP_XOR;
          6'h27: dec_op_s = OP_NOR;
          6'h2A: dec_op_s = OP_SLT;
          6'h2B: dec_op_s = OP_SLTU;
          6'h00: begin dec_op_s = OP_SLL; dec_a_s = {27'd0, shamt_s}; end
          6'h02: begin dec_op_s = OP_SRL; dec_a_s = {27'd0, shamt_s}; end
          6'h03: begin dec_op_s = OP_SRA; dec_a_s = {27'd0, shamt_s}; end
          6'h04: begin dec_op_s = OP_SLL; dec_a_s = {27'd0, rs_val_s[4:0]}; end
          6'h06: begin dec_op_s = OP_SRL; dec_a_s = {27'd0, rs_val_s[4:0]}; end
          6'h07: begin dec_op_s = OP_SRA; dec_a_s = {27'd0, rs_val_s[4:0]}; end
          6'h0A: begin
            dec_op_s  = OP_MOV;
            dec_a_s   = 32'd0;
            dec_b_s   = rs_val_s;
            wb_cond_s = (rt_val_s == 32'd0);
          end
          6'h0B: begin
            dec_op_s  = OP_MOV;
            dec_a_s   = 32'd0;
            dec_b_s   = rs_val_s;
            wb_cond_s = (rt_val_s != 32'd0);
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      6'h08: begin dec_op_s = OP_ADD;  dec_dst_s = rt_f_s; dec_b_s = {{16{imm_s[15]}}, imm_s}; end
      6'h09: begin dec_op_s = OP_ADDU; dec_dst_s = rt_f_s; dec_b_s = {{16{imm_s[15]}}, imm_s}; end
      6'h0A: begin dec_op_s = OP_SLT;  dec_dst_s = rt_f_s; dec_b_s = {{16{imm_s[15]}}, imm_s}; end
      6'h0B: begin dec_op_s = OP_SLTU; dec_dst_s = rt_f_s; dec_b_s = {{16{imm_s[15]}}, imm_s}; end
      6'h23: begin dec_op_s = OP_ADDU; dec_dst_s = rt_f_s; dec_b_s = {{16{imm_s[15]}}, imm_s}; end
      6'h2B: begin
        dec_op_s  = OP_ADDU;
        dec_dst_s = rt_f_s;
        dec_b_s   = {{16{imm_s[15]}}, imm_s};
        wb_cond_s = 1'b0;
      end
      6'h0C: begin dec_op_s = OP_AND; dec_dst_s = rt_f_s; dec_b_s = {16'd0, imm_s}; end
      6'h0D: begin dec_op_s = OP_OR;  dec_dst_s = rt_f_s; dec_b_s = {16'd0, imm_s}; end
      6'h0E: begin dec_op_s = OP_XOR; dec_dst_s = rt_f_s; dec_b_s = {16'd0, imm_s}; end
      6'h0F: begin
        dec_op_s  = OP_LUI;
        dec_dst_s = rt_f_s;
        dec_a_s   = 32'd0;
        dec_b_s   = {16'd0, imm_s};
      end
      default: dec_ill_s = 1'b1;
    endcase
    // Unsupported encodings travel down the pipe as a harmless NOP
    if (dec_ill_s) begin
      dec_op_s  = OP_NOP;
      dec_a_s   = 32'd0;
      dec_b_s   = 32'd0;
      dec_dst_s = 5'd0;
      dec_wb_s  = 1'b0;
    end else begin
      dec_wb_s  = wb_cond_s & (dec_dst_s != 5'd0);
    end
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign hs_s     = out_valid_q & out_ready;
  assign load_s   = in_valid & in_ready & ~flush;

  // Next-state for the pipeline slot and issue counter
  always_comb begin
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
    end else if (hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (load_s) begin
      alu_a_d   = dec_a_s;
      alu_b_d   = dec_b_s;
      alu_op_d  = dec_op_s;
      dst_d     = dec_dst_s;
      wb_en_d   = dec_wb_s;
      illegal_d = dec_ill_s;
    end else begin
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      dst_d     = dst_q;
      wb_en_d   = wb_en_q;
      illegal_d = illegal_q;
    end
    if (hs_s && !flush) begin
      issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      issue_cnt_d = issue_cnt_q;
    end
  end

  // Slot and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_op_q    <= 5'd0;
      dst_q       <= 5'd0;
      wb_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      issue_cnt_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      wb_en_q     <= wb_en_d;
      illegal_q   <= illegal_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign dst       = dst_q;
  assign wb_en     = wb_en_q;
  assign illegal   = illegal_q;
  assign issue_cnt = issue_cnt_q;

endmodule
